// File: rtl/timer_pulse_cnt_if.sv
// Control/status bundle between the timer and its register/interrupt block.
// Latency: none, wires only.
// Backpressure: none; tick and strobes are single-cycle, status is level.
interface timer_pulse_cnt_if #(
  parameter int WD = 16
);
  logic          pulse_1us_i;
  logic          cfg_enable;
  logic          cfg_mode;
  logic [WD-1:0] cfg_load;
  logic          cfg_start;
  logic          int_clr;
  logic [WD-1:0] timer_cnt_o;
  logic          timer_busy_o;
  logic          timer_expire_o;
  logic          timer_int_o;

  // Drives configuration and tick, observes timer status.
  modport master (
    output pulse_1us_i, cfg_enable, cfg_mode, cfg_load, cfg_start, int_clr,
    input  timer_cnt_o, timer_busy_o, timer_expire_o, timer_int_o
  );

  // The timer itself.
  modport slave (
    input  pulse_1us_i, cfg_enable, cfg_mode, cfg_load, cfg_start, int_clr,
    output timer_cnt_o, timer_busy_o, timer_expire_o, timer_int_o
  );
endinterface

// File: rtl/timer_pulse_cnt.sv
// Down-counting 1 us timer, one-shot or periodic; load N gives N+1 ticks.
// Latency: expire/int visible one clk after the edge sampling the terminal tick.
// Backpressure: none; every high cycle of pulse_1us_i is consumed as a tick.
module timer_pulse_cnt #(
  parameter int WD = 16
) (
  input  logic               clk,
  input  logic               reset,
  timer_pulse_cnt_if.slave   tif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [WD-1:0] cnt, cnt_nxt;
  logic          busy;
  logic          expire, expire_nxt;
  logic          int_flag, int_nxt;

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      expire   <= 1'b0;
      int_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= (state_nxt == RUN);
      expire   <= expire_nxt;
      int_flag <= int_nxt;
    end
  end

  // Next-state logic: disable overrides all, start overrides tick, expire set beats int_clr.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    expire_nxt = 1'b0;
    int_nxt    = int_flag & ~tif.int_clr;

    if (!tif.cfg_enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (tif.cfg_start) begin
            state_nxt = RUN;
            cnt_nxt   = tif.cfg_load;
          end
        end
        RUN: begin
          if (tif.cfg_start) begin
            cnt_nxt = tif.cfg_load;
          end else if (tif.pulse_1us_i) begin
            if (cnt != '0) begin
              cnt_nxt = cnt - 1'b1;
            end else begin
              expire_nxt = 1'b1;
              int_nxt    = 1'b1;
              if (tif.cfg_mode) begin
                cnt_nxt = tif.cfg_load;
              end else begin
                state_nxt = DONE;
                cnt_nxt   = '0;
              end
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign tif.timer_cnt_o    = cnt;
  assign tif.timer_busy_o   = busy;
  assign tif.timer_expire_o = expire;
  assign tif.timer_int_o    = int_flag;

endmodule

// File: tb/tb_timer_pulse_cnt.sv
// Directed bench for timer_pulse_cnt with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Fixed-length stimulus, no open-ended waits.
module tb_timer_pulse_cnt;

  localparam int WD = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_q[$];

  timer_pulse_cnt_if #(.WD(WD)) tif ();

  timer_pulse_cnt #(.WD(WD)) dut (
    .clk   (clk),
    .reset (reset),
    .tif   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chkc(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: apply strobes, let the rising edge sample them, return at the falling edge.
  task automatic step(input logic p, input logic s, input logic c);
    tif.pulse_1us_i = p;
    tif.cfg_start   = s;
    tif.int_clr     = c;
    @(posedge clk);
    @(negedge clk);
    tif.pulse_1us_i = 1'b0;
    tif.cfg_start   = 1'b0;
    tif.int_clr     = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    tif.pulse_1us_i = 1'b0;
    tif.cfg_enable  = 1'b0;
    tif.cfg_mode    = 1'b0;
    tif.cfg_load    = '0;
    tif.cfg_start   = 1'b0;
    tif.int_clr     = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chkc("rst_cnt", tif.timer_cnt_o, 16'd0);
    chk1("rst_busy", tif.timer_busy_o, 1'b0);
    chk1("rst_expire", tif.timer_expire_o, 1'b0);
    chk1("rst_int", tif.timer_int_o, 1'b0);
    reset = 1'b0;

    // Ticks without start stay idle
    tif.cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chkc("idle_cnt", tif.timer_cnt_o, 16'd0);
    chk1("idle_busy", tif.timer_busy_o, 1'b0);

    // One-shot, load 3: 3,2,1,0 then expire on the 4th tick
    tif.cfg_mode = 1'b0;
    tif.cfg_load = 16'd3;
    step(1'b0, 1'b1, 1'b0);
    chkc("os_cnt_start", tif.timer_cnt_o, 16'd3);
    chk1("os_busy_start", tif.timer_busy_o, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chkc("os_cnt_t1", tif.timer_cnt_o, 16'd2);
    step(1'b1, 1'b0, 1'b0);
    chkc("os_cnt_t2", tif.timer_cnt_o, 16'd1);
    step(1'b1, 1'b0, 1'b0);
    chkc("os_cnt_t3", tif.timer_cnt_o, 16'd0);
    chk1("os_noexp_t3", tif.timer_expire_o, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk1("os_expire_t4", tif.timer_expire_o, 1'b1);
    chk1("os_int_t4", tif.timer_int_o, 1'b1);
    chk1("os_busy_t4", tif.timer_busy_o, 1'b0);
    chkc("os_cnt_t4", tif.timer_cnt_o, 16'd0);
    step(1'b0, 1'b0, 1'b0);
    chk1("os_expire_1clk", tif.timer_expire_o, 1'b0);
    chk1("os_int_sticky", tif.timer_int_o, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk1("os_done_noexp", tif.timer_expire_o, 1'b0);
    chk1("os_done_busy", tif.timer_busy_o, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk1("int_clr", tif.timer_int_o, 1'b0);

    // Periodic, load 1, tick every 10 clks; load changes to 4 mid-period at clk 65
    tif.cfg_mode = 1'b1;
    tif.cfg_load = 16'd1;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 135; i++) begin
      if (i == 65) tif.cfg_load = 16'd4;
      step((i % 10) == 9, 1'b0, 1'b0);
      if (tif.timer_expire_o) exp_q.push_back(i);
    end
    chkc("per_num_expires", 16'(exp_q.size()), 16'd5);
    if (exp_q.size() == 5) begin
      chkc("per_exp0", 16'(exp_q[0]), 16'd19);
      chkc("per_exp1", 16'(exp_q[1]), 16'd39);
      chkc("per_exp2", 16'(exp_q[2]), 16'd59);
      chkc("per_exp3_oldload", 16'(exp_q[3]), 16'd79);
      chkc("per_exp4_newload", 16'(exp_q[4]), 16'd129);
    end
    chkc("per_cnt_reload", tif.timer_cnt_o, 16'd4);
    chk1("per_busy", tif.timer_busy_o, 1'b1);

    // Interrupt race: clear coincides with terminal tick, set wins
    step(1'b0, 1'b0, 1'b1);
    chk1("race_pre_clr", tif.timer_int_o, 1'b0);
    tif.cfg_mode = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chkc("race_cnt0", tif.timer_cnt_o, 16'd0);
    step(1'b1, 1'b0, 1'b1);
    chk1("race_expire", tif.timer_expire_o, 1'b1);
    chk1("race_int_set_wins", tif.timer_int_o, 1'b1);
    chk1("race_oneshot_done", tif.timer_busy_o, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk1("race_int_cleared", tif.timer_int_o, 1'b0);

    // Disable at cnt 5 (starting from DONE)
    tif.cfg_mode = 1'b1;
    tif.cfg_load = 16'd8;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chkc("dis_cnt5", tif.timer_cnt_o, 16'd5);
    tif.cfg_enable = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    chkc("dis_cnt", tif.timer_cnt_o, 16'd0);
    chk1("dis_busy", tif.timer_busy_o, 1'b0);
    chk1("dis_noexp", tif.timer_expire_o, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk1("dis_start_ignored", tif.timer_busy_o, 1'b0);
    tif.cfg_enable = 1'b1;

    // Restart at cnt 2 together with a tick: start beats tick
    tif.cfg_load = 16'd4;
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chkc("rs_cnt2", tif.timer_cnt_o, 16'd2);
    tif.cfg_load = 16'd6;
    step(1'b1, 1'b1, 1'b0);
    chkc("rs_cnt6", tif.timer_cnt_o, 16'd6);
    chk1("rs_busy", tif.timer_busy_o, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chkc("rs_cnt5", tif.timer_cnt_o, 16'd5);

    // Load 0 periodic with a continuous tick: expire every clk
    tif.cfg_load = 16'd0;
    step(1'b0, 1'b1, 1'b0);
    chkc("edge_cnt_start", tif.timer_cnt_o, 16'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk1("edge_expire", tif.timer_expire_o, 1'b1);
      chkc("edge_cnt", tif.timer_cnt_o, 16'd0);
    end

    // Asynchronous reset mid-run at cnt 7
    tif.cfg_load = 16'd7;
    step(1'b0, 1'b1, 1'b0);
    chkc("ar_cnt7", tif.timer_cnt_o, 16'd7);
    chk1("ar_int_before", tif.timer_int_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    chkc("ar_cnt", tif.timer_cnt_o, 16'd0);
    chk1("ar_busy", tif.timer_busy_o, 1'b0);
    chk1("ar_expire", tif.timer_expire_o, 1'b0);
    chk1("ar_int", tif.timer_int_o, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chkc("ar_post_cnt", tif.timer_cnt_o, 16'd0);
    chk1("ar_post_busy", tif.timer_busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
